sramlike_mem_responder: RTL and testbench

SRAMLIKE_MEM_RESPONDER -- requirements
Module: sramlike_mem_responder

---
 rtl/sramlike_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_sramlike_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sramlike_mem_responder.sv
// Single-outstanding SRAM-like memory responder: a programmable address-accept wait,
// then a programmable data latency, over a byte-enabled 32-bit backing array.
module sramlike_mem_responder #(
    parameter int ADDR_LAT  = 0,
    parameter int DATA_LAT  = 1,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] ALAT    = 4'(ADDR_LAT);
    localparam logic [3:0] LAT_END = 4'(DATA_LAT - 2);

    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    lane_en = 4'b0001 << a;
            2'd1:    lane_en = a[1] ? 4'b1100 : 4'b0011;
            2'd2:    lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    logic [31:0]      mem [MEM_WORDS];

    logic [1:0]       state_q, state_d;
    logic [3:0]       acnt_q, acnt_d;
    logic [3:0]       lcnt_q, lcnt_d;
    logic             wr_q;
    logic             bad_q;
    logic [3:0]       be_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q, rdata_d;

    logic             accept_s;
    logic             cur_wr_s;
    logic             cur_bad_s;
    logic [IDX_W-1:0] cur_idx_s;
    logic             unused_addr_s;

    assign accept_s      = (state_q == ST_IDLE) && req && (acnt_q == ALAT);
    assign addr_ok       = accept_s;
    assign data_ok       = (state_q == ST_RESP);
    assign err           = (state_q == ST_RESP) && bad_q;
    assign rdata         = rdata_q;
    assign unused_addr_s = ^addr[31:IDX_W+2];

    // With DATA_LAT=1 the read happens on the handshake edge, so the live inputs stand in for captured fields.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_wr_s  = wr;
            cur_bad_s = misaligned(size, addr[1:0]);
            cur_idx_s = addr[IDX_W+1:2];
        end else begin
            cur_wr_s  = wr_q;
            cur_bad_s = bad_q;
            cur_idx_s = idx_q;
        end
    end

    // Next-state, counter and read-data logic.
    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        lcnt_d  = lcnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    acnt_d  = 4'd0;
                    lcnt_d  = 4'd0;
                    state_d = (DATA_LAT <= 1) ? ST_RESP : ST_BUSY;
                end else if (req) begin
                    acnt_d = acnt_q + 4'd1;
                end else begin
                    acnt_d = 4'd0;
                end
            end
            ST_BUSY: begin
                if (lcnt_q == LAT_END) begin
                    lcnt_d  = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    lcnt_d = lcnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                acnt_d  = 4'd0;
                lcnt_d  = 4'd0;
            end
        endcase
        if ((state_d == ST_RESP) && (state_q != ST_RESP) && !cur_wr_s && !cur_bad_s) begin
            rdata_d = mem[cur_idx_s];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control state, transaction capture and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acnt_q  <= 4'd0;
            lcnt_q  <= 4'd0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            lcnt_q  <= lcnt_d;
            rdata_q <= rdata_d;
            if (accept_s) begin
                wr_q    <= wr;
                bad_q   <= misaligned(size, addr[1:0]);
                be_q    <= lane_en(size, addr[1:0]);
                idx_q   <= addr[IDX_W+1:2];
                wdata_q <= wdata;
            end
        end
    end

    // Backing array: never reset; a commit lands on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_RESP) && wr_q && !bad_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Directed bench for sramlike_mem_responder: one instance at default latencies,
// one at ADDR_LAT=2 / DATA_LAT=3.
module tb_sramlike_mem_responder;

    logic        clk = 1'b0;
    logic        rst0, req0, wr0, ok0, dok0, err0;
    logic        rst1, req1, wr1, ok1, dok1, err1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, wdata0, rdata0;
    logic [31:0] addr1, wdata1, rdata1;
    logic        sel = 1'b0;
    logic        ok_m, dok_m, err_m;
    logic [31:0] rdata_m;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    sramlike_mem_responder u0 (
        .clk(clk), .rst(rst0), .req(req0), .wr(wr0), .size(size0), .addr(addr0),
        .wdata(wdata0), .addr_ok(ok0), .data_ok(dok0), .rdata(rdata0), .err(err0)
    );

    sramlike_mem_responder #(.ADDR_LAT(2), .DATA_LAT(3), .MEM_WORDS(1024)) u1 (
        .clk(clk), .rst(rst1), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
        .wdata(wdata1), .addr_ok(ok1), .data_ok(dok1), .rdata(rdata1), .err(err1)
    );

    assign ok_m    = sel ? ok1 : ok0;
    assign dok_m   = sel ? dok1 : dok0;
    assign err_m   = sel ? err1 : err0;
    assign rdata_m = sel ? rdata1 : rdata0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic s, input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        sel = s;
        if (s) begin
            req1 = r; wr1 = w; size1 = sz; addr1 = a; wdata1 = wd;
        end else begin
            req0 = r; wr0 = w; size0 = sz; addr0 = a; wdata0 = wd;
        end
    endtask

    // One full transaction; entered and left 1 ns after a rising edge.
    task automatic txn(input logic s, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int alat, input int dlat, input logic e,
                       input logic chk_rd, input logic [31:0] rd, input string tag);
        int  n;
        bit  seen;
        drv(s, 1'b1, w, sz, a, wd);
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            #1;
            if (ok_m) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1; n++;
            end
        end
        check_eq({tag, " addr_ok cycle"}, seen ? n : -1, alat);
        @(posedge clk); #1;
        drv(s, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        n = 1; seen = 1'b0;
        while (n < 40 && !seen) begin
            #1;
            if (dok_m) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1; n++;
            end
        end
        check_eq({tag, " data_ok latency"}, seen ? n : -1, dlat);
        check_eq({tag, " err"}, 32'(err_m), 32'(e));
        if (chk_rd) check_eq({tag, " rdata"}, rdata_m, rd);
        @(posedge clk); #2;
        check_eq({tag, " data_ok pulse"}, 32'(dok_m), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        rst0 = 1'b1; rst1 = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drv(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset outs u0", {rdata0[28:0], ok0, dok0, err0}, 32'd0);
        check_eq("reset rdata u0", rdata0, 32'd0);
        check_eq("reset outs u1", {rdata1[28:0], ok1, dok1, err1}, 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // Default latencies: basic write/read and rdata hold through a write
        txn(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 1, 1'b0, 1'b0, 32'd0, "wr10");
        txn(1'b0, 1'b0, 2'd2, 32'h10, 32'd0, 0, 1, 1'b0, 1'b1, 32'hDEADBEEF, "rd10");
        txn(1'b0, 1'b1, 2'd2, 32'h10, 32'h11223344, 0, 1, 1'b0, 1'b1, 32'hDEADBEEF, "wr10 hold");
        txn(1'b0, 1'b1, 2'd0, 32'h13, 32'hAAAAAAAA, 0, 1, 1'b0, 1'b0, 32'd0, "wrb13");
        txn(1'b0, 1'b0, 2'd2, 32'h10, 32'd0, 0, 1, 1'b0, 1'b1, 32'hAA223344, "rd after byte");
        txn(1'b0, 1'b1, 2'd1, 32'h12, 32'h55665566, 0, 1, 1'b0, 1'b0, 32'd0, "wrh12");
        txn(1'b0, 1'b0, 2'd0, 32'h11, 32'd0, 0, 1, 1'b0, 1'b1, 32'h55663344, "rd byte full word");

        // Misaligned and illegal-size accesses
        txn(1'b0, 1'b1, 2'd2, 32'h00, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0, 32'd0, "wr00");
        txn(1'b0, 1'b1, 2'd2, 32'h02, 32'h12345678, 0, 1, 1'b1, 1'b0, 32'd0, "wr02 misaligned");
        txn(1'b0, 1'b0, 2'd2, 32'h00, 32'd0, 0, 1, 1'b0, 1'b1, 32'hCAFEF00D, "rd00 unchanged");
        txn(1'b0, 1'b0, 2'd3, 32'h10, 32'd0, 0, 1, 1'b1, 1'b1, 32'hCAFEF00D, "size3 rd");
        txn(1'b0, 1'b1, 2'd1, 32'h11, 32'hFFFFFFFF, 0, 1, 1'b1, 1'b0, 32'd0, "wrh11 misaligned");
        txn(1'b0, 1'b0, 2'd2, 32'h10, 32'd0, 0, 1, 1'b0, 1'b1, 32'h55663344, "rd10 unchanged");

        // Address wrap
        txn(1'b0, 1'b1, 2'd2, 32'h1000, 32'h12345678, 0, 1, 1'b0, 1'b0, 32'd0, "wr1000");
        txn(1'b0, 1'b0, 2'd2, 32'h0, 32'd0, 0, 1, 1'b0, 1'b1, 32'h12345678, "rd00 wrap");

        // Longer latencies
        txn(1'b1, 1'b1, 2'd2, 32'h20, 32'h5A5A5A5A, 2, 3, 1'b0, 1'b0, 32'd0, "u1 wr20");
        txn(1'b1, 1'b0, 2'd2, 32'h20, 32'd0, 2, 3, 1'b0, 1'b1, 32'h5A5A5A5A, "u1 rd20");

        // Request withdrawn after one cycle
        drv(1'b1, 1'b1, 1'b0, 2'd2, 32'h20, 32'd0);
        cnt = 0;
        #1; if (ok1) cnt++;
        @(posedge clk); #1;
        drv(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            #1; if (ok1 || dok1) cnt++;
            @(posedge clk); #1;
        end
        check_eq("u1 dropped req no handshake", cnt, 32'd0);

        // Reset while BUSY aborts a write
        drv(1'b1, 1'b1, 1'b1, 2'd2, 32'h20, 32'hFFFFFFFF);
        repeat (2) begin @(posedge clk); #1; end
        #1;
        check_eq("u1 abort accept", 32'(ok1), 32'd1);
        @(posedge clk); #1;
        drv(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        rst1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1; if (dok1) cnt++;
            @(posedge clk); #1;
            if (i == 1) rst1 = 1'b0;
        end
        check_eq("u1 abort no data_ok", cnt, 32'd0);
        #1;
        check_eq("u1 post-rst outs", {29'd0, ok1, dok1, err1}, 32'd0);
        check_eq("u1 post-rst rdata", rdata1, 32'd0);
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 2'd2, 32'h20, 32'd0, 2, 3, 1'b0, 1'b1, 32'h5A5A5A5A, "u1 rd20 kept");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
